// File: rtl/read_burst_scheduler.sv
// rtl/read_burst_scheduler.sv - read command queue and dfi_rddata_en window scheduler
module read_burst_scheduler #(
  parameter int DEPTH = 4,
  parameter int RL_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [RL_W-1:0]  rl_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_bl_i,
  input  logic [2:0]       cmd_pre_i,
  input  logic             cmd_post_i,
  input  logic             cmd_crc_i,
  input  logic             cmd_crc_mode_i,
  input  logic             ovf_i,
  output logic             dfi_rddata_en_o,
  output logic [2:0]       pre_amble_sett_o,
  output logic [1:0]       bl_o,
  output logic             post_amble_sett_o,
  output logic             read_crc_enable_o,
  output logic             phy_crc_mode_o,
  output logic             busy_o,
  output logic             err_ovf_o,
  output logic [CNT_W-1:0] win_count_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_RL, BURST, HALT} state_t;

  typedef struct packed {
    logic [2:0] pre;
    logic [1:0] bl;
    logic       post;
    logic       crc;
    logic       crc_mode;
  } cmd_t;

  // Window length in clocks; reserved BL encoding falls back to 8 clocks.
  function automatic logic [4:0] win_len(input logic [1:0] bl, input logic crc);
    logic [4:0] base;
    case (bl)
      2'b01:   base = 5'd4;
      2'b10:   base = 5'd16;
      default: base = 5'd8;
    endcase
    return base + {4'b0, crc};
  endfunction

  state_t          state_q, state_d;
  cmd_t            mem_q [DEPTH];
  cmd_t            mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  cmd_t            set_q, set_d;
  logic [RL_W-1:0] rl_cnt_q, rl_cnt_d;
  logic [4:0]      beat_q, beat_d;
  logic            err_q, err_d;
  logic [CNT_W-1:0] win_q, win_d;

  logic            full, empty, push, pop, flush;
  logic [RL_W-1:0] rl_eff;
  cmd_t            head, cmd_in;

  assign full        = (count_q == (AW+1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign cmd_ready_o = en_i & ~full & (state_q != HALT) & ~reset_i;
  assign push        = cmd_valid_i & cmd_ready_o;
  assign head        = mem_q[rd_ptr_q];
  assign cmd_in      = {cmd_pre_i, cmd_bl_i, cmd_post_i, cmd_crc_i, cmd_crc_mode_i};
  assign rl_eff      = (rl_i == '0) ? RL_W'(1) : rl_i;

  always_comb begin
    state_d  = state_q;
    set_d    = set_q;
    rl_cnt_d = rl_cnt_q;
    beat_d   = beat_q;
    err_d    = err_q;
    win_d    = win_q;
    pop      = 1'b0;
    flush    = 1'b0;
    if (!en_i) begin
      state_d = IDLE;
      flush   = 1'b1;
      err_d   = 1'b0;
    end else if (ovf_i) begin
      state_d = HALT;
      flush   = 1'b1;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (!empty) begin
          pop   = 1'b1;
          set_d = head;
          if (rl_eff == RL_W'(1)) begin
            state_d = BURST;
            beat_d  = win_len(head.bl, head.crc) - 5'd1;
          end else begin
            state_d  = WAIT_RL;
            rl_cnt_d = rl_eff - RL_W'(1);
          end
        end
        WAIT_RL: begin
          rl_cnt_d = rl_cnt_q - RL_W'(1);
          if (rl_cnt_q == RL_W'(1)) begin
            state_d = BURST;
            beat_d  = win_len(set_q.bl, set_q.crc) - 5'd1;
          end
        end
        BURST: begin
          beat_d = beat_q - 5'd1;
          if (beat_q == 5'd0) begin
            win_d = win_q + CNT_W'(1);
            // Back-to-back commands chain with no idle cycle and no new RL wait.
            if (!empty) begin
              pop    = 1'b1;
              set_d  = head;
              beat_d = win_len(head.bl, head.crc) - 5'd1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = HALT;
      endcase
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = cmd_in;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      set_q    <= '0;
      rl_cnt_q <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      set_q    <= set_d;
      rl_cnt_q <= rl_cnt_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      win_q    <= win_d;
    end
  end

  assign dfi_rddata_en_o   = (state_q == BURST);
  assign pre_amble_sett_o  = set_q.pre;
  assign bl_o              = set_q.bl;
  assign post_amble_sett_o = set_q.post;
  assign read_crc_enable_o = set_q.crc;
  assign phy_crc_mode_o    = set_q.crc_mode;
  assign busy_o            = (state_q != IDLE) | ~empty;
  assign err_ovf_o         = err_q;
  assign win_count_o       = win_q;

endmodule

// File: tb/tb_read_burst_scheduler.sv
// tb/tb_read_burst_scheduler.sv - directed bench with settings scoreboard for read_burst_scheduler
module tb_read_burst_scheduler;

  logic        clk_i = 1'b0;
  logic        reset_i, en_i, cmd_valid_i, cmd_ready_o, ovf_i;
  logic [4:0]  rl_i;
  logic [1:0]  cmd_bl_i, bl_o;
  logic [2:0]  cmd_pre_i, pre_amble_sett_o;
  logic        cmd_post_i, cmd_crc_i, cmd_crc_mode_i;
  logic        dfi_rddata_en_o, post_amble_sett_o, read_crc_enable_o, phy_crc_mode_o;
  logic        busy_o, err_ovf_o;
  logic [15:0] win_count_o;

  read_burst_scheduler dut (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .rl_i(rl_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_bl_i(cmd_bl_i),
    .cmd_pre_i(cmd_pre_i), .cmd_post_i(cmd_post_i), .cmd_crc_i(cmd_crc_i),
    .cmd_crc_mode_i(cmd_crc_mode_i), .ovf_i(ovf_i), .dfi_rddata_en_o(dfi_rddata_en_o),
    .pre_amble_sett_o(pre_amble_sett_o), .bl_o(bl_o), .post_amble_sett_o(post_amble_sett_o),
    .read_crc_enable_o(read_crc_enable_o), .phy_crc_mode_o(phy_crc_mode_o),
    .busy_o(busy_o), .err_ovf_o(err_ovf_o), .win_count_o(win_count_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];
  logic mon_on = 1'b0;
  int rem = 0;

  function automatic int tb_len(input logic [1:0] bl, input logic crc);
    int n;
    n = (bl == 2'b01) ? 4 : (bl == 2'b10) ? 16 : 8;
    return n + int'(crc);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_cmd(input logic [1:0] bl, input logic [2:0] pre, input logic post,
                          input logic crc, input logic mode);
    int tries = 0;
    cmd_valid_i = 1'b1;
    cmd_bl_i = bl; cmd_pre_i = pre; cmd_post_i = post; cmd_crc_i = crc; cmd_crc_mode_i = mode;
    #1;
    while (!cmd_ready_o && tries < 200) begin
      @(posedge clk_i);
      #2;
      tries++;
    end
    chk("push_accepted", tries < 200, 1);
    if (tries < 200) sb.push_back({pre, bl, post, crc, mode});
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  // Window monitor: each new window must match the oldest queued command, and run unbroken.
  always @(negedge clk_i) begin
    logic [7:0] e;
    if (reset_i || !mon_on) begin
      rem = 0;
    end else if (dfi_rddata_en_o) begin
      if (rem == 0) begin
        chk("window_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("window_settings", {pre_amble_sett_o, bl_o, post_amble_sett_o,
                                  read_crc_enable_o, phy_crc_mode_o}, e);
          rem = tb_len(e[4:3], e[1]);
        end else begin
          rem = 1;
        end
      end
      rem--;
    end else begin
      chk("window_no_gap", rem, 0);
      rem = 0;
    end
  end

  initial begin
    int base, run, w, hi;
    reset_i = 1'b1; en_i = 1'b1; rl_i = 5'd5; cmd_valid_i = 1'b0; ovf_i = 1'b0;
    cmd_bl_i = 2'b00; cmd_pre_i = 3'd0; cmd_post_i = 1'b0; cmd_crc_i = 1'b0; cmd_crc_mode_i = 1'b0;
    step(); step();
    chk("reset_outputs", {dfi_rddata_en_o, pre_amble_sett_o, bl_o, post_amble_sett_o,
                          read_crc_enable_o, phy_crc_mode_o, busy_o, err_ovf_o, win_count_o}, 0);
    reset_i = 1'b0;
    mon_on = 1'b1;
    step();
    chk("idle_ready", cmd_ready_o, 1);

    // rl=5, single BL16: enable cycles 6..13 counting the push cycle as 0
    push_cmd(2'b00, 3'd2, 1'b1, 1'b0, 1'b1);
    for (int n = 1; n <= 16; n++) begin
      chk($sformatf("rl5_en_c%0d", n), dfi_rddata_en_o, (n >= 6 && n <= 13));
      step();
    end
    chk("rl5_win_count", win_count_o, 1);

    // three BL8 back-to-back, last with CRC: 4+4+5 contiguous enable cycles
    rl_i = 5'd3;
    base = win_count_o;
    push_cmd(2'b01, 3'd1, 1'b0, 1'b0, 1'b0);
    push_cmd(2'b01, 3'd3, 1'b1, 1'b0, 1'b1);
    push_cmd(2'b01, 3'd6, 1'b0, 1'b1, 1'b0);
    w = 0;
    while (!dfi_rddata_en_o && w < 50) begin step(); w++; end
    chk("seamless_start", w < 50, 1);
    run = 0;
    while (dfi_rddata_en_o && run < 50) begin step(); run++; end
    chk("seamless_len", run, 13);
    chk("seamless_win_count", win_count_o, base + 3);
    chk("seamless_last_crc", read_crc_enable_o, 1);

    // five pushes against a 4-deep queue while the first window waits on RL
    rl_i = 5'd10;
    base = win_count_o;
    for (int i = 0; i < 5; i++) push_cmd(2'b10, 3'(i), 1'(i), 1'b0, 1'(i >> 1));
    chk("full_ready_low", cmd_ready_o, 0);
    chk("full_busy", busy_o, 1);
    w = 0;
    while (busy_o && w < 500) begin step(); w++; end
    chk("full_drained", w < 500, 1);
    chk("full_win_count", win_count_o, base + 5);
    chk("full_sb_empty", sb.size(), 0);

    // overflow mid-burst
    rl_i = 5'd2;
    base = win_count_o;
    push_cmd(2'b10, 3'd4, 1'b0, 1'b0, 1'b0);
    push_cmd(2'b10, 3'd5, 1'b0, 1'b0, 1'b0);
    w = 0;
    while (!dfi_rddata_en_o && w < 50) begin step(); w++; end
    chk("ovf_burst_start", w < 50, 1);
    step(); step(); step();
    mon_on = 1'b0;
    ovf_i = 1'b1;
    step();
    ovf_i = 1'b0;
    chk("ovf_en_drop", dfi_rddata_en_o, 0);
    chk("ovf_err_set", err_ovf_o, 1);
    chk("ovf_ready_low", cmd_ready_o, 0);
    chk("ovf_win_unchanged", win_count_o, base);
    step(); step(); step();
    chk("ovf_halt_held", {dfi_rddata_en_o, busy_o, cmd_ready_o}, 3'b010);
    en_i = 1'b0;
    step();
    chk("disable_err_clr", err_ovf_o, 0);
    chk("disable_flushed", busy_o, 0);
    en_i = 1'b1;
    #1;
    chk("reenable_ready", cmd_ready_o, 1);
    sb.delete();
    mon_on = 1'b1;
    step();

    // rl=0 behaves as 1; reserved BL gives an 8-clock window
    rl_i = 5'd0;
    push_cmd(2'b11, 3'd5, 1'b1, 1'b0, 1'b0);
    for (int n = 1; n <= 12; n++) begin
      chk($sformatf("rl0_en_c%0d", n), dfi_rddata_en_o, (n >= 2 && n <= 9));
      step();
    end
    chk("rl0_bl_out", bl_o, 2'b11);
    chk("rl0_pre_out", pre_amble_sett_o, 3'd5);

    // reset while waiting on RL
    rl_i = 5'd10;
    push_cmd(2'b00, 3'd7, 1'b1, 1'b1, 1'b1);
    step(); step(); step();
    mon_on = 1'b0;
    reset_i = 1'b1;
    step();
    chk("midrst_outputs", {dfi_rddata_en_o, pre_amble_sett_o, bl_o, post_amble_sett_o,
                           read_crc_enable_o, phy_crc_mode_o, busy_o, err_ovf_o, win_count_o}, 0);
    reset_i = 1'b0;
    sb.delete();
    mon_on = 1'b1;
    hi = 0;
    repeat (30) begin
      step();
      if (dfi_rddata_en_o) hi++;
    end
    chk("midrst_no_window", hi, 0);
    chk("midrst_idle", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
